// File: rtl/dac_prep_pkg.sv
// Shared encodings and code-conversion helpers for the DAC DDR feeder.
package dac_prep_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_MID    = 2'd2,
        MODE_CONST  = 2'd3
    } mode_e;

    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] midscale(input int unsigned width);
        return MAX_W'(1) << (width - 1);
    endfunction

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [MAX_W-1:0] to_offset_bin(input logic [MAX_W-1:0] value,
                                                       input int unsigned     width);
        return value ^ midscale(width);
    endfunction

endpackage

// File: rtl/dac_prep_fifo.sv
// Sample-pair FIFO, fall-through read; an entry becomes visible one edge after it is written.
module dac_prep_fifo #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          full_next
);

    localparam int unsigned DEPTH = 1 << aw;
    localparam logic [aw:0] DEPTH_C = {1'b1, {aw{1'b0}}};
    localparam logic [aw:0] ONE_C   = {{aw{1'b0}}, 1'b1};

    logic [dw-1:0] mem_q [DEPTH];
    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0]   count_q, count_d;
    logic          pushed_q, pushed_d;
    logic          do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    // A lone entry written at the last edge is still in flight to the read side.
    assign empty   = (count_q == '0) | ((count_q == ONE_C) & pushed_q);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pushed_d = do_push;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    assign full_next = (count_d == DEPTH_C);

    // NOTE: storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pushed_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pushed_q <= pushed_d;
        end
    end

endmodule

// File: rtl/dac_ddr_prep.sv
// DAC DDR feeder: stream FIFO, test patterns, offset-binary output registers, underflow counter.
module dac_ddr_prep
    import dac_prep_pkg::*;
#(
    parameter int unsigned width   = 16,
    parameter int unsigned fifo_aw = 2,
    parameter int unsigned cnt_w   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [width-1:0] const_val,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [width-1:0] s_d0,
    input  logic [width-1:0] s_d1,
    output logic [width-1:0] data0,
    output logic [width-1:0] data1,
    output logic             underflow,
    output logic [cnt_w-1:0] underflow_count,
    input  logic             clear_count
);

    localparam logic [width-1:0] MID = width'(midscale(width));

    mode_e              mode_s;
    logic [2*width-1:0] fifo_dout;
    logic               fifo_empty, fifo_full, fifo_full_next;
    logic               push, pop;

    logic [width-1:0]   data0_q, data0_d;
    logic [width-1:0]   data1_q, data1_d;
    logic [width-1:0]   ramp_q, ramp_d;
    logic               s_ready_q, s_ready_d;
    logic               underflow_q, underflow_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;

    assign mode_s = mode_e'(mode);
    assign push   = s_valid & s_ready_q & ~fifo_full;
    assign pop    = enable & (mode_s == MODE_STREAM) & ~fifo_empty;

    dac_prep_fifo #(
        .dw (2 * width),
        .aw (fifo_aw)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (~enable),
        .push      (push),
        .pop       (pop),
        .din       ({s_d1, s_d0}),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .full_next (fifo_full_next)
    );

    always_comb begin
        data0_d     = MID;
        data1_d     = MID;
        ramp_d      = '0;
        underflow_d = 1'b0;
        if (enable) begin
            case (mode_s)
                MODE_STREAM: begin
                    if (!fifo_empty) begin
                        data0_d = width'(to_offset_bin(MAX_W'(fifo_dout[width-1:0]), width));
                        data1_d = width'(to_offset_bin(MAX_W'(fifo_dout[2*width-1:width]), width));
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                MODE_RAMP: begin
                    data0_d = ramp_q;
                    data1_d = ramp_q + 1'b1;
                    ramp_d  = ramp_q + width'(2);
                end
                MODE_CONST: begin
                    data0_d = width'(to_offset_bin(MAX_W'(const_val), width));
                    data1_d = data0_d;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready_d = enable & ~fifo_full_next;
        cnt_d     = cnt_q;
        if (clear_count)                     cnt_d = '0;
        else if (underflow_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data0_q     <= MID;
            data1_q     <= MID;
            ramp_q      <= '0;
            s_ready_q   <= 1'b0;
            underflow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            ramp_q      <= ramp_d;
            s_ready_q   <= s_ready_d;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign data0           = data0_q;
    assign data1           = data1_q;
    assign s_ready         = s_ready_q;
    assign underflow       = underflow_q;
    assign underflow_count = cnt_q;

endmodule

// File: tb/tb_dac_ddr_prep.sv
// Directed bench for dac_ddr_prep: per-cycle vector table plus hand sequences for saturation, wrap and reset.
module tb_dac_ddr_prep;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] const_val;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_d0, s_d1;
    logic [15:0] data0, data1;
    logic        underflow;
    logic [15:0] underflow_count;
    logic        clear_count;

    logic        en4;
    logic [1:0]  mode4;
    logic        s_ready4;
    logic [3:0]  data0_4, data1_4;
    logic        underflow4;
    logic [15:0] count4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dac_ddr_prep #(.width(16), .fifo_aw(2), .cnt_w(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .mode            (mode),
        .const_val       (const_val),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_d0            (s_d0),
        .s_d1            (s_d1),
        .data0           (data0),
        .data1           (data1),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .clear_count     (clear_count)
    );

    dac_ddr_prep #(.width(4), .fifo_aw(2), .cnt_w(16)) dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (en4),
        .mode            (mode4),
        .const_val       (4'h0),
        .s_valid         (1'b0),
        .s_ready         (s_ready4),
        .s_d0            (4'h0),
        .s_d1            (4'h0),
        .data0           (data0_4),
        .data1           (data1_4),
        .underflow       (underflow4),
        .underflow_count (count4),
        .clear_count     (1'b0)
    );

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic [15:0] cval;
        logic        vld;
        logic [15:0] d0, d1;
        logic        clr;
        logic [15:0] e0, e1;
        logic        erdy;
        logic        euf;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic en, input logic [1:0] md, input logic [15:0] cval,
                                input logic vld, input logic [15:0] d0, input logic [15:0] d1,
                                input logic clr, input logic [15:0] e0, input logic [15:0] e1,
                                input logic erdy, input logic euf, input logic [15:0] ecnt);
        vec_t v;
        v.en = en; v.md = md; v.cval = cval; v.vld = vld; v.d0 = d0; v.d1 = d1; v.clr = clr;
        v.e0 = e0; v.e1 = e1; v.erdy = erdy; v.euf = euf; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic erdy, input logic euf, input logic [15:0] ecnt);
        check({tag, " data0"}, 32'(data0), 32'(e0));
        check({tag, " data1"}, 32'(data1), 32'(e1));
        check({tag, " s_ready"}, 32'(s_ready), 32'(erdy));
        check({tag, " underflow"}, 32'(underflow), 32'(euf));
        check({tag, " count"}, 32'(underflow_count), 32'(ecnt));
    endtask

    initial begin
        //                en md cval     vld d0       d1       clr e0       e1       rdy uf cnt
        vecs[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd1);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd2);
        vecs[2]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h8000, 16'h8000, 1, 1, 16'd0);
        vecs[3]  = mk(1, 0, 16'h0000, 1, 16'h0000, 16'hFFFF, 0, 16'h8000, 16'h8000, 1, 1, 16'd1);
        vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h7FFF, 16'h8000, 0, 16'h8000, 16'h8000, 1, 1, 16'd2);
        vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h7FFF, 1, 0, 16'd2);
        vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 1, 0, 16'd2);
        vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd3);
        vecs[8]  = mk(1, 3, 16'hFFFE, 0, 16'h0000, 16'h0000, 0, 16'h7FFE, 16'h7FFE, 1, 0, 16'd3);
        vecs[9]  = mk(1, 3, 16'h1234, 0, 16'h0000, 16'h0000, 0, 16'h9234, 16'h9234, 1, 0, 16'd3);
        vecs[10] = mk(1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0001, 1, 0, 16'd3);
        vecs[11] = mk(1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0003, 1, 0, 16'd3);
        vecs[12] = mk(1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h0005, 1, 0, 16'd3);
        vecs[13] = mk(1, 2, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 0, 16'd3);
        vecs[14] = mk(1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0001, 1, 0, 16'd3);
        vecs[15] = mk(1, 2, 16'h0000, 1, 16'h0001, 16'h0002, 0, 16'h8000, 16'h8000, 1, 0, 16'd3);
        vecs[16] = mk(1, 2, 16'h0000, 1, 16'h0003, 16'h0004, 0, 16'h8000, 16'h8000, 1, 0, 16'd3);
        vecs[17] = mk(1, 2, 16'h0000, 1, 16'h0005, 16'h0006, 0, 16'h8000, 16'h8000, 1, 0, 16'd3);
        vecs[18] = mk(1, 2, 16'h0000, 1, 16'h0007, 16'h0008, 0, 16'h8000, 16'h8000, 0, 0, 16'd3);
        vecs[19] = mk(1, 2, 16'h0000, 1, 16'h0009, 16'h000A, 0, 16'h8000, 16'h8000, 0, 0, 16'd3);
        vecs[20] = mk(1, 2, 16'h0000, 1, 16'h0009, 16'h000A, 0, 16'h8000, 16'h8000, 0, 0, 16'd3);
        vecs[21] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8001, 16'h8002, 1, 0, 16'd3);
        vecs[22] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8003, 16'h8004, 1, 0, 16'd3);
        vecs[23] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8005, 16'h8006, 1, 0, 16'd3);
        vecs[24] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8007, 16'h8008, 1, 0, 16'd3);
        vecs[25] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd4);
        vecs[26] = mk(1, 0, 16'h0000, 1, 16'h1111, 16'h2222, 0, 16'h8000, 16'h8000, 1, 1, 16'd5);
        vecs[27] = mk(1, 0, 16'h0000, 1, 16'h3333, 16'h4444, 0, 16'h8000, 16'h8000, 1, 1, 16'd6);
        vecs[28] = mk(0, 0, 16'h0000, 1, 16'h5555, 16'h6666, 0, 16'h8000, 16'h8000, 0, 0, 16'd6);
        vecs[29] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 0, 0, 16'd6);
        vecs[30] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd7);
        vecs[31] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 1, 16'd8);

        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; const_val = '0;
        s_valid = 1'b0; s_d0 = '0; s_d1 = '0; clear_count = 1'b0;
        en4 = 1'b0; mode4 = 2'd0;
        step();
        step();
        check_all("reset", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'd0);
        check("reset dut4 data0", 32'(data0_4), 32'h8);
        check("reset dut4 data1", 32'(data1_4), 32'h8);

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            enable = vecs[i].en; mode = vecs[i].md; const_val = vecs[i].cval;
            s_valid = vecs[i].vld; s_d0 = vecs[i].d0; s_d1 = vecs[i].d1;
            clear_count = vecs[i].clr;
            step();
            check_all($sformatf("v%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].erdy,
                      vecs[i].euf, vecs[i].ecnt);
        end
        s_valid = 1'b0; clear_count = 1'b0;

        // Saturation: count all-ones then hold, clear wins over a coincident underflow.
        enable = 1'b1; mode = 2'd0; clear_count = 1'b1;
        step();
        check("sat clear", 32'(underflow_count), 32'd0);
        clear_count = 1'b0;
        for (int i = 0; i < 65535; i++) step();
        check("sat reach", 32'(underflow_count), 32'hFFFF);
        for (int i = 0; i < 3; i++) step();
        check("sat hold", 32'(underflow_count), 32'hFFFF);
        check("sat underflow", 32'(underflow), 32'd1);
        clear_count = 1'b1;
        step();
        check("sat clear2", 32'(underflow_count), 32'd0);
        clear_count = 1'b0;

        // Narrow build ramp: expect 0/1, 2/3 ... 14/15, then wrap to 0/1.
        en4 = 1'b1; mode4 = 2'd1;
        for (int i = 0; i < 9; i++) begin
            logic [3:0] e0, e1;
            e0 = 4'(2 * i);
            e1 = e0 + 4'd1;
            step();
            check($sformatf("ramp4 %0d data0", i), 32'(data0_4), 32'(e0));
            check($sformatf("ramp4 %0d data1", i), 32'(data1_4), 32'(e1));
        end

        // Reset mid-stream drops the queued pair.
        clear_count = 1'b0; enable = 1'b1; mode = 2'd0;
        s_valid = 1'b1; s_d0 = 16'h0100; s_d1 = 16'h0200;
        step();
        s_d0 = 16'h0300; s_d1 = 16'h0400;
        step();
        s_valid = 1'b0;
        step();
        check("mid data0", 32'(data0), 32'h8100);
        check("mid data1", 32'(data1), 32'h8200);
        rst_n = 1'b0;
        step();
        check_all("rst mid", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        step();
        check_all("post rst1", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'd1);
        step();
        check_all("post rst2", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
